// File: rtl/alu_op_sequencer.sv
// Sequential front end for the combinational ALU: registers operands/select, waits SETTLE cycles,
// captures result/flags and returns them on a valid/ready response. Optional macro: ALU_STICKY_FLAGS_EN.
module alu_op_sequencer #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_sel,
  input  logic [TAG_W-1:0] req_tag,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flag,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err
`ifdef ALU_STICKY_FLAGS_EN
  ,
  input  logic             sticky_clr,
  output logic [3:0]       sticky_flag
`endif
);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  state_t           state;
  logic [3:0]       cnt;
  logic [TAG_W-1:0] tag_q;
  logic             sel_illegal;

  always_comb begin
    req_ready   = (state == IDLE);
    sel_illegal = (req_sel[2:1] == 2'b11);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      tag_q      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_flag   <= '0;
      rsp_tag    <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (sel_illegal) begin
              // Illegal ops never touch the ALU; answer immediately with an error.
              rsp_err    <= 1'b1;
              rsp_result <= '0;
              rsp_flag   <= '0;
              rsp_tag    <= req_tag;
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end else begin
              alu_a   <= req_a;
              alu_b   <= req_b;
              alu_sel <= req_sel;
              tag_q   <= req_tag;
              cnt     <= CNT_LOAD;
              state   <= DRIVE;
            end
          end
        end
        DRIVE: begin
          if (cnt == '0) begin
            rsp_result <= alu_result;
            rsp_flag   <= alu_flag;
            rsp_tag    <= tag_q;
            rsp_err    <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_STICKY_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst || sticky_clr) begin
      sticky_flag <= '0;
    end else if (state == DRIVE && cnt == '0) begin
      sticky_flag <= sticky_flag | alu_flag;
    end
  end
`endif

endmodule
